// File: rtl/score_ctl_if.sv
// Point-event / score-display bundle between the game logic and score_ctl.
// master = game logic side (drives pulses), slave = score controller.
interface score_ctl_if;
  logic        start;
  logic        point_me;
  logic        point_op;
  logic [13:0] my_score_ASCII_1;
  logic [13:0] my_score_ASCII_0;
  logic [13:0] op_score_ASCII_1;
  logic [13:0] op_score_ASCII_0;
  logic [6:0]  number_of_player;
  logic        game_over;
  logic        play_active;
  logic        score_screen;

  modport master (
    output start, point_me, point_op,
    input  my_score_ASCII_1, my_score_ASCII_0, op_score_ASCII_1, op_score_ASCII_0,
    input  number_of_player, game_over, play_active, score_screen
  );

  modport slave (
    input  start, point_me, point_op,
    output my_score_ASCII_1, my_score_ASCII_0, op_score_ASCII_1, op_score_ASCII_0,
    output number_of_player, game_over, play_active, score_screen
  );
endinterface

// File: rtl/score_ctl.sv
// Game-score controller: per-player 2-digit BCD counters, IDLE/PLAY/OVER phase FSM,
// ASCII formatting for the score ROM. Optional macro SCORE_LEADING_BLANK_EN blanks a zero tens digit.

module score_bcd #(
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       at_win
);
  logic [3:0] tens_n, units_n;
  logic [6:0] bin_n;

  // Incremented value, saturating at 99; at_win compares it, the top gates it with inc.
  always_comb begin
    tens_n  = tens;
    units_n = units;
    if (!(tens == 4'd9 && units == 4'd9)) begin
      if (units == 4'd9) begin
        units_n = 4'd0;
        tens_n  = tens + 4'd1;
      end else begin
        units_n = units + 4'd1;
      end
    end
    bin_n  = 7'(tens_n) * 7'd10 + 7'(units_n);
    at_win = (bin_n == 7'(WIN_SCORE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      tens  <= tens_n;
      units <= units_n;
    end
  end
endmodule

module score_ctl #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned HOLD_CYCLES = 130000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  score_ctl_if.slave bus
);
  localparam int unsigned    NUM_PLY   = 2;
  localparam logic [6:0]     ASC_SPACE = 7'h20;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t state, state_n;
  logic                        clr;
  logic [NUM_PLY-1:0]          inc, at_win, hit;
  logic [NUM_PLY-1:0][3:0]     tens, units;
  logic [NUM_PLY-1:0][6:0]     asc_t, asc_u;
  logic [CNT_W-1:0]            hold_cnt;
  logic [6:0]                  winner, winner_n;
  logic                        game_over_q, play_active_q, score_screen_q;

  function automatic logic [6:0] tens_asc(input logic [3:0] d);
`ifdef SCORE_LEADING_BLANK_EN
    return (d == 4'd0) ? ASC_SPACE : 7'h30 + 7'(d);
`else
    return 7'h30 + 7'(d);
`endif
  endfunction

  // start outranks point pulses, so counters only see increments in PLAY without start.
  assign inc = (state == PLAY && !bus.start) ? {bus.point_op, bus.point_me} : '0;
  assign hit = inc & at_win;

  for (genvar p = 0; p < NUM_PLY; p++) begin : g_ply
    score_bcd #(.WIN_SCORE(WIN_SCORE)) u_bcd (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .inc    (inc[p]),
      .tens   (tens[p]),
      .units  (units[p]),
      .at_win (at_win[p])
    );
  end

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    winner_n = winner;
    case (state)
      IDLE: if (bus.start) begin
        clr      = 1'b1;
        winner_n = ASC_SPACE;
        state_n  = PLAY;
      end
      PLAY: begin
        if (bus.start) begin
          clr      = 1'b1;
          winner_n = ASC_SPACE;
        end else if (hit[0]) begin
          winner_n = 7'h31;
          state_n  = OVER;
        end else if (hit[1]) begin
          winner_n = 7'h32;
          state_n  = OVER;
        end
      end
      OVER: begin
        if (bus.start) begin
          clr      = 1'b1;
          winner_n = ASC_SPACE;
          state_n  = PLAY;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      winner   <= ASC_SPACE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      winner   <= winner_n;
      hold_cnt <= (state == OVER && state_n == OVER) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Display registers trail the counters and state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PLY; p++) begin
        asc_t[p] <= tens_asc(4'd0);
        asc_u[p] <= 7'h30;
      end
      game_over_q    <= 1'b0;
      play_active_q  <= 1'b0;
      score_screen_q <= 1'b1;
    end else begin
      for (int p = 0; p < NUM_PLY; p++) begin
        asc_t[p] <= tens_asc(tens[p]);
        asc_u[p] <= 7'h30 + 7'(units[p]);
      end
      game_over_q    <= (state == OVER);
      play_active_q  <= (state == PLAY);
      score_screen_q <= (state != PLAY);
    end
  end

  assign bus.my_score_ASCII_1 = {7'b0, asc_t[0]};
  assign bus.my_score_ASCII_0 = {7'b0, asc_u[0]};
  assign bus.op_score_ASCII_1 = {7'b0, asc_t[1]};
  assign bus.op_score_ASCII_0 = {7'b0, asc_u[1]};
  assign bus.number_of_player = winner;
  assign bus.game_over        = game_over_q;
  assign bus.play_active      = play_active_q;
  assign bus.score_screen     = score_screen_q;
endmodule

// File: tb/tb_score_ctl.sv
// Bench for score_ctl: three instances (WIN_SCORE 20/3/2, HOLD 5) share directed stimulus;
// an integer-score model checks every output each cycle, plus hand-computed spot checks.
module tb_score_ctl;
  localparam int HOLD = 5;
`ifdef SCORE_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [13:0] T0 = BLANK ? 14'h0020 : 14'h0030;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, point_me = 1'b0, point_op = 1'b0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  score_ctl_if if0 ();
  score_ctl_if if1 ();
  score_ctl_if if2 ();
  assign {if0.start, if0.point_me, if0.point_op} = {start, point_me, point_op};
  assign {if1.start, if1.point_me, if1.point_op} = {start, point_me, point_op};
  assign {if2.start, if2.point_me, if2.point_op} = {start, point_me, point_op};

  score_ctl #(.WIN_SCORE(20), .HOLD_CYCLES(HOLD), .CNT_W(32)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  score_ctl #(.WIN_SCORE(3),  .HOLD_CYCLES(HOLD), .CNT_W(32)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  score_ctl #(.WIN_SCORE(2),  .HOLD_CYCLES(HOLD), .CNT_W(32)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Collected DUT outputs, indexed by instance.
  logic [13:0] a_m1[3], a_m0[3], a_o1[3], a_o0[3];
  logic [6:0]  a_np[3];
  logic        a_go[3], a_pa[3], a_ss[3];
  assign {a_m1[0], a_m0[0], a_o1[0], a_o0[0], a_np[0], a_go[0], a_pa[0], a_ss[0]} =
    {if0.my_score_ASCII_1, if0.my_score_ASCII_0, if0.op_score_ASCII_1, if0.op_score_ASCII_0,
     if0.number_of_player, if0.game_over, if0.play_active, if0.score_screen};
  assign {a_m1[1], a_m0[1], a_o1[1], a_o0[1], a_np[1], a_go[1], a_pa[1], a_ss[1]} =
    {if1.my_score_ASCII_1, if1.my_score_ASCII_0, if1.op_score_ASCII_1, if1.op_score_ASCII_0,
     if1.number_of_player, if1.game_over, if1.play_active, if1.score_screen};
  assign {a_m1[2], a_m0[2], a_o1[2], a_o0[2], a_np[2], a_go[2], a_pa[2], a_ss[2]} =
    {if2.my_score_ASCII_1, if2.my_score_ASCII_0, if2.op_score_ASCII_1, if2.op_score_ASCII_0,
     if2.number_of_player, if2.game_over, if2.play_active, if2.score_screen};

  // Model: phase 0 idle / 1 play / 2 over, scores as plain integers.
  int ws[3] = '{20, 3, 2};
  int ph[3], me[3], op[3], wn[3], hd[3];
  logic [13:0] x_m1[3], x_m0[3], x_o1[3], x_o0[3];
  logic [6:0]  x_np[3];
  logic        x_go[3], x_pa[3], x_ss[3];

  function automatic logic [13:0] tasc(input int d);
    if (BLANK && d == 0) return 14'h0020;
    return 14'h0030 + 14'(d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ph[i] = 0; me[i] = 0; op[i] = 0; wn[i] = 'h20; hd[i] = 0;
        x_m1[i] = tasc(0); x_o1[i] = tasc(0); x_m0[i] = 14'h30; x_o0[i] = 14'h30;
        x_go[i] = 1'b0; x_pa[i] = 1'b0; x_ss[i] = 1'b1;
      end else begin
        x_m1[i] = tasc(me[i] / 10); x_m0[i] = 14'h30 + 14'(me[i] % 10);
        x_o1[i] = tasc(op[i] / 10); x_o0[i] = 14'h30 + 14'(op[i] % 10);
        x_go[i] = (ph[i] == 2); x_pa[i] = (ph[i] == 1); x_ss[i] = (ph[i] != 1);
        if (start) begin
          me[i] = 0; op[i] = 0; wn[i] = 'h20; ph[i] = 1;
        end else if (ph[i] == 1) begin
          if (point_me && me[i] < 99) me[i]++;
          if (point_op && op[i] < 99) op[i]++;
          if ((point_me && me[i] == ws[i]) || (point_op && op[i] == ws[i])) begin
            wn[i] = (point_me && me[i] == ws[i]) ? 'h31 : 'h32;
            ph[i] = 2; hd[i] = 0;
          end
        end else if (ph[i] == 2) begin
          if (hd[i] == HOLD - 1) ph[i] = 0;
          else hd[i]++;
        end
      end
      x_np[i] = 7'(wn[i]);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d my1", i), 32'(a_m1[i]), 32'(x_m1[i]));
      chk($sformatf("i%0d my0", i), 32'(a_m0[i]), 32'(x_m0[i]));
      chk($sformatf("i%0d op1", i), 32'(a_o1[i]), 32'(x_o1[i]));
      chk($sformatf("i%0d op0", i), 32'(a_o0[i]), 32'(x_o0[i]));
      chk($sformatf("i%0d winner", i), 32'(a_np[i]), 32'(x_np[i]));
      chk($sformatf("i%0d game_over", i), 32'(a_go[i]), 32'(x_go[i]));
      chk($sformatf("i%0d play_active", i), 32'(a_pa[i]), 32'(x_pa[i]));
      chk($sformatf("i%0d score_screen", i), 32'(a_ss[i]), 32'(x_ss[i]));
    end
  end

  task automatic step(input logic s, input logic pm, input logic po);
    start = s; point_me = pm; point_op = po;
    @(negedge clk);
    start = 1'b0; point_me = 1'b0; point_op = 1'b0;
  endtask

  initial begin
    // Reset held for 3 cycles, then idle with ignored point pulses.
    repeat (3) step(0, 0, 0);
    rst_n = 1'b1;
    chk("lit reset my0", 32'(if0.my_score_ASCII_0), 32'h30);
    chk("lit reset my1", 32'(if0.my_score_ASCII_1), 32'(T0));
    chk("lit reset winner", 32'(if0.number_of_player), 32'h20);
    chk("lit reset screen", 32'(if0.score_screen), 32'h1);
    step(0, 1, 1); step(0, 1, 0); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    chk("lit idle my0", 32'(if0.my_score_ASCII_0), 32'h30);
    chk("lit idle op0", 32'(if0.op_score_ASCII_0), 32'h30);

    // BCD carry: 12 points -> "12" on the WIN_SCORE=20 instance.
    step(1, 0, 0);
    repeat (12) step(0, 1, 0);
    step(0, 0, 0);
    chk("lit carry my1", 32'(if0.my_score_ASCII_1), 32'h31);
    chk("lit carry my0", 32'(if0.my_score_ASCII_0), 32'h32);

    // Player 2 wins at 3, then the 5-cycle hold expires.
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    chk("lit p2 game_over", 32'(if1.game_over), 32'h1);
    chk("lit p2 winner", 32'(if1.number_of_player), 32'h32);
    chk("lit p2 screen", 32'(if1.score_screen), 32'h1);
    repeat (5) step(0, 0, 0);
    chk("lit hold game_over", 32'(if1.game_over), 32'h0);
    chk("lit hold op0", 32'(if1.op_score_ASCII_0), 32'h33);
    chk("lit hold op1", 32'(if1.op_score_ASCII_1), 32'(T0));
    chk("lit hold winner", 32'(if1.number_of_player), 32'h32);

    // Simultaneous points from 1:1 on WIN_SCORE=2: player 1 wins.
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); step(0, 1, 1); step(0, 0, 0);
    chk("lit simul my0", 32'(if2.my_score_ASCII_0), 32'h32);
    chk("lit simul op0", 32'(if2.op_score_ASCII_0), 32'h32);
    chk("lit simul winner", 32'(if2.number_of_player), 32'h31);

    // start beats point_me in PLAY; start in OVER restarts play.
    step(1, 1, 0); step(0, 0, 0);
    chk("lit prio my0", 32'(if1.my_score_ASCII_0), 32'h30);
    chk("lit restart play", 32'(if2.play_active), 32'h1);
    chk("lit restart winner", 32'(if2.number_of_player), 32'h20);

    // Reset for one cycle while OVER.
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    chk("lit pre-rst game_over", 32'(if1.game_over), 32'h1);
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    chk("lit rst game_over", 32'(if1.game_over), 32'h0);
    chk("lit rst op1", 32'(if1.op_score_ASCII_1), 32'(T0));
    chk("lit rst op0", 32'(if1.op_score_ASCII_0), 32'h30);
    chk("lit rst winner", 32'(if1.number_of_player), 32'h20);
    chk("lit rst screen", 32'(if1.score_screen), 32'h1);
    repeat (4) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_ctl.md
Name: score_ctl

Overview:
Game-score controller that sequences the score text screen.
- Counts points for both players as 2-digit BCD and formats them as ASCII character codes for the score character ROM.
- Detects the winner and runs the game phase (idle / play / game-over hold).
- Tells the VGA overlay which screen to show.
- Sits between the game-logic point-event pulses and the score character ROM / text overlay path.

Parameters:
WIN_SCORE, 10, points needed to win (decimal, legal range 1..99)
HOLD_CYCLES, 130000000, clk cycles the game-over screen is held before returning to idle (2 s at 65 MHz); legal range 1..2^32-1
CNT_W, 32, width of the hold counter

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  synchronous reset, active low
start  in  1  1-cycle pulse: begin a new game
point_me  in  1  1-cycle pulse: player 1 scored
point_op  in  1  1-cycle pulse: player 2 scored
my_score_ASCII_1  out  14  player 1 tens digit ASCII in [6:0], [13:7]=0
my_score_ASCII_0  out  14  player 1 units digit ASCII in [6:0], [13:7]=0
op_score_ASCII_1  out  14  player 2 tens digit ASCII in [6:0], [13:7]=0
op_score_ASCII_0  out  14  player 2 units digit ASCII in [6:0], [13:7]=0
number_of_player  out  7  winner ASCII: 7'h31 '1', 7'h32 '2', 7'h20 ' ' while no winner
game_over  out  1  high in OVER state
play_active  out  1  high in PLAY state
score_screen  out  1  1 = overlay shows the score/win screen (IDLE or OVER), 0 = gameplay screen

Behaviour:
- Single clock domain. rst_n is synchronous and active low, sampled on the rising edge of clk. All state is updated on the rising edge of clk.
- Reset values:
  - state = IDLE; both BCD counters = 00; hold counter = 0.
  - All ASCII score outputs = 14'h0030.
  - number_of_player = 7'h20; game_over = 0; play_active = 0; score_screen = 1.
- State machine: IDLE, PLAY, OVER.
  - IDLE: on start -> clear both scores to 00 and go to PLAY. Point pulses are ignored.
  - PLAY:
    - point_me increments player 1 BCD (units 9 -> 0 with tens+1); point_op likewise for player 2.
    - Saturate at 99.
    - Both pulses in the same cycle: both counters increment.
    - When a post-increment score equals WIN_SCORE -> OVER next cycle and latch the winner. If both reach WIN_SCORE in the same cycle, player 1 wins.
    - start in PLAY restarts: scores -> 00, stay in PLAY. start has priority over point pulses in the same cycle.
  - OVER:
    - Point pulses are ignored; the hold counter counts 0..HOLD_CYCLES-1.
    - At terminal count -> IDLE; scores and winner are kept for display.
    - start in OVER -> scores 00, winner cleared, go to PLAY immediately.
- Winner register:
  - Set on entry to OVER.
  - Cleared (7'h20) on entry to PLAY.
  - Unaffected by the OVER -> IDLE transition.
- Output latency:
  - ASCII outputs are registered from the BCD counters. Output = 7'h30 + digit, 1 cycle after the counter update, i.e. 2 edges after the pulse is sampled.
  - game_over, play_active and score_screen are registered decodes of state (1 cycle after the state change).
- Reset mid-game returns to the IDLE reset values regardless of state.
- WIN_SCORE comparison uses the binary value 10*tens + units.

Optional Feature:
Macro SCORE_LEADING_BLANK_EN.
- Defined: a tens-digit output shows 7'h20 (space) when its tens digit is 0, so a score of 7 renders " 7".
- Not defined: the tens digit is always 7'h30 + digit, so 7 renders "07".
- Units digits are unaffected in both cases. Reset values of the tens outputs follow the same rule (14'h0020 when defined).

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release -> ASCII outputs 14'h0030, number_of_player 7'h20, score_screen 1. Point pulses in IDLE leave the scores at 00.
- BCD carry: start, then 12 point_me pulses -> my_score_ASCII_1=14'h0031, my_score_ASCII_0=14'h0032, 2 edges after the last pulse. Use WIN_SCORE=20.
- Win, player 2: WIN_SCORE=3, HOLD_CYCLES=5; start, then 3 point_op pulses -> game_over=1, number_of_player=7'h32, score_screen=1. After 5 cycles: game_over=0, scores still "03", winner still '2'.
- Simultaneous: WIN_SCORE=2, score 1:1, point_me and point_op in the same cycle -> both "02", winner 7'h31.
- Start priority / restart: start together with point_me during PLAY -> scores 00. start during OVER -> play_active=1, winner 7'h20 next cycle.
- Reset mid-OVER: assert rst_n=0 for 1 cycle during OVER -> all outputs at reset values on the next cycle. Repeat with SCORE_LEADING_BLANK_EN defined -> tens outputs 14'h0020.
